// File: rtl/ddr3_dfi_responder.sv
// DFI-side DDR3 stand-in: decodes commands, tracks open rows, stores write bursts in a 32-bit RAM.
// Read beats return DDR_READ_LATENCY cycles after rddata_en; no backpressure, misuse is flagged on sticky err_o.
module ddr3_dfi_responder #(
    parameter int DDR_READ_LATENCY = 4,
    parameter int MEM_ADDR_W       = 10,
    parameter int CMD_FIFO_DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [14:0] dfi_address_i,
    input  logic [2:0]  dfi_bank_i,
    input  logic        dfi_cs_n_i,
    input  logic        dfi_ras_n_i,
    input  logic        dfi_cas_n_i,
    input  logic        dfi_we_n_i,
    input  logic        dfi_cke_i,
    input  logic        dfi_odt_i,
    input  logic        dfi_reset_n_i,
    input  logic [31:0] dfi_wrdata_i,
    input  logic        dfi_wrdata_en_i,
    input  logic [3:0]  dfi_wrdata_mask_i,
    input  logic        dfi_rddata_en_i,
    output logic [31:0] dfi_rddata_o,
    output logic        dfi_rddata_valid_o,
    output logic [1:0]  dfi_rddata_dnv_o,
    output logic        err_o
);
    localparam int QW        = $clog2(CMD_FIFO_DEPTH);
    localparam int CW        = QW + 1;
    localparam int RAM_DEPTH = 1 << MEM_ADDR_W;
    localparam int LAT       = DDR_READ_LATENCY;
    localparam logic [CW-1:0] FULL_CNT = CMD_FIFO_DEPTH[CW-1:0];
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;

    typedef logic [MEM_ADDR_W-1:0] addr_t;

    logic [7:0]    open_q, open_d;
    logic [14:0]   row_q [8];
    logic [14:0]   row_d [8];
    addr_t         rq_mem_q [CMD_FIFO_DEPTH];
    addr_t         rq_mem_d [CMD_FIFO_DEPTH];
    addr_t         wq_mem_q [CMD_FIFO_DEPTH];
    addr_t         wq_mem_d [CMD_FIFO_DEPTH];
    logic [QW-1:0] rq_head_q, rq_head_d, wq_head_q, wq_head_d;
    logic [CW-1:0] rq_cnt_q, rq_cnt_d, wq_cnt_q, wq_cnt_d;
    logic [1:0]    rd_beat_q, rd_beat_d, wr_beat_q, wr_beat_d;
    logic [LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [31:0]   pipe_dat_q [LAT];
    logic [31:0]   pipe_dat_d [LAT];
    logic          err_q, err_d;
    logic [31:0]   mem_q [RAM_DEPTH];

    logic          cmd_vld;
    logic [2:0]    cmd;
    logic [26:0]   base_full;
    addr_t         cmd_base, rd_addr, wr_addr;
    logic          rq_full, wq_full, rq_push, wq_push, rq_pop, wq_pop;
    logic          rd_fire, wr_fire;
    logic [31:0]   rd_dat;
    logic          unused_bits;

    assign cmd_vld   = ~dfi_cs_n_i & dfi_cke_i & dfi_reset_n_i;
    assign cmd       = {dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i};
    assign base_full = {row_q[dfi_bank_i], dfi_bank_i, dfi_address_i[9:3], 2'b00};
    assign cmd_base  = base_full[MEM_ADDR_W-1:0];
    assign rq_full   = (rq_cnt_q == FULL_CNT);
    assign wq_full   = (wq_cnt_q == FULL_CNT);
    assign rd_fire   = dfi_rddata_en_i && (rq_cnt_q != '0);
    assign wr_fire   = dfi_wrdata_en_i && (wq_cnt_q != '0);
    assign rd_addr   = rq_mem_q[rq_head_q] + addr_t'(rd_beat_q);
    assign wr_addr   = wq_mem_q[wq_head_q] + addr_t'(wr_beat_q);
    // Asynchronous RAM read registered into the pipe: a same-cycle write is not yet visible.
    assign rd_dat    = rd_fire ? mem_q[rd_addr] : '0;
    assign unused_bits = ^{dfi_odt_i, base_full[26:MEM_ADDR_W]};

    always_comb begin
        open_d    = open_q;
        row_d     = row_q;
        err_d     = err_q;
        rq_mem_d  = rq_mem_q;
        wq_mem_d  = wq_mem_q;
        rd_beat_d = rd_beat_q;
        wr_beat_d = wr_beat_q;
        rq_push   = 1'b0;
        wq_push   = 1'b0;
        rq_pop    = 1'b0;
        wq_pop    = 1'b0;
        pipe_vld_d = pipe_vld_q;
        pipe_dat_d = pipe_dat_q;

        if (cmd_vld) begin
            case (cmd)
                CMD_ACT: begin
                    if (open_q[dfi_bank_i]) err_d = 1'b1;
                    open_d[dfi_bank_i] = 1'b1;
                    row_d[dfi_bank_i]  = dfi_address_i;
                end
                CMD_PRE: begin
                    if (dfi_address_i[10]) open_d = '0;
                    else                   open_d[dfi_bank_i] = 1'b0;
                end
                CMD_REF: if (|open_q) err_d = 1'b1;
                CMD_RD: begin
                    if (!open_q[dfi_bank_i] || rq_full) err_d = 1'b1;
                    else begin
                        rq_push = 1'b1;
                        if (dfi_address_i[10]) open_d[dfi_bank_i] = 1'b0;
                    end
                end
                CMD_WR: begin
                    if (!open_q[dfi_bank_i] || wq_full) err_d = 1'b1;
                    else begin
                        wq_push = 1'b1;
                        if (dfi_address_i[10]) open_d[dfi_bank_i] = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (dfi_rddata_en_i) begin
            if (rd_fire) begin
                rd_beat_d = rd_beat_q + 2'd1;
                rq_pop    = (rd_beat_q == 2'd3);
            end else begin
                err_d = 1'b1;
            end
        end
        if (dfi_wrdata_en_i) begin
            if (wr_fire) begin
                wr_beat_d = wr_beat_q + 2'd1;
                wq_pop    = (wr_beat_q == 2'd3);
            end else begin
                err_d = 1'b1;
            end
        end

        if (rq_push) rq_mem_d[rq_head_q + rq_cnt_q[QW-1:0]] = cmd_base;
        if (wq_push) wq_mem_d[wq_head_q + wq_cnt_q[QW-1:0]] = cmd_base;
        rq_head_d = rq_pop ? rq_head_q + QW'(1) : rq_head_q;
        wq_head_d = wq_pop ? wq_head_q + QW'(1) : wq_head_q;
        rq_cnt_d  = rq_cnt_q + CW'(rq_push) - CW'(rq_pop);
        wq_cnt_d  = wq_cnt_q + CW'(wq_push) - CW'(wq_pop);

        // Data stages only load on a valid beat so the last stage holds the previous output.
        pipe_vld_d[0] = dfi_rddata_en_i;
        if (dfi_rddata_en_i) pipe_dat_d[0] = rd_dat;
        for (int i = 1; i < LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            if (pipe_vld_q[i-1]) pipe_dat_d[i] = pipe_dat_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            open_q     <= '0;
            err_q      <= 1'b0;
            rq_head_q  <= '0;
            wq_head_q  <= '0;
            rq_cnt_q   <= '0;
            wq_cnt_q   <= '0;
            rd_beat_q  <= '0;
            wr_beat_q  <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < 8; i++) row_q[i] <= '0;
            for (int i = 0; i < CMD_FIFO_DEPTH; i++) begin
                rq_mem_q[i] <= '0;
                wq_mem_q[i] <= '0;
            end
            for (int i = 0; i < LAT; i++) pipe_dat_q[i] <= '0;
        end else begin
            open_q     <= open_d;
            err_q      <= err_d;
            rq_head_q  <= rq_head_d;
            wq_head_q  <= wq_head_d;
            rq_cnt_q   <= rq_cnt_d;
            wq_cnt_q   <= wq_cnt_d;
            rd_beat_q  <= rd_beat_d;
            wr_beat_q  <= wr_beat_d;
            pipe_vld_q <= pipe_vld_d;
            row_q      <= row_d;
            rq_mem_q   <= rq_mem_d;
            wq_mem_q   <= wq_mem_d;
            pipe_dat_q <= pipe_dat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (!dfi_wrdata_mask_i[b]) mem_q[wr_addr][8*b +: 8] <= dfi_wrdata_i[8*b +: 8];
            end
        end
    end

    assign dfi_rddata_o       = pipe_dat_q[LAT-1];
    assign dfi_rddata_valid_o = pipe_vld_q[LAT-1];
    assign dfi_rddata_dnv_o   = 2'b00;
    assign err_o              = err_q;
endmodule

// File: doc/ddr3_dfi_responder.md
Name: ddr3_dfi_responder

Overview:
- Synthesizable DFI-side responder: the far end of the DFI interface that the DDR3 controller core drives.
- Decodes DFI commands, tracks open rows per bank, and stores write bursts in an internal RAM. Returns read bursts on dfi_rddata at a fixed latency.
- Used as an FPGA-internal DDR3 stand-in and as a bench target for the AXI-to-DDR3 controller, with sticky protocol-error reporting.

Parameters:
- DDR_READ_LATENCY, 4, cycles from dfi_rddata_en_i beat to dfi_rddata_valid_o beat; legal range 1..15.
- MEM_ADDR_W, 10, log2 depth of the internal 32-bit word RAM.
- CMD_FIFO_DEPTH, 4, entries in each of the read and write burst-address queues; must be a power of 2.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous, active-low reset.
- dfi_address_i  in  15  row/column address; A10 = auto/all-banks.
- dfi_bank_i  in  3  bank address.
- dfi_cs_n_i  in  1  chip select, active low.
- dfi_ras_n_i  in  1  RAS, active low.
- dfi_cas_n_i  in  1  CAS, active low.
- dfi_we_n_i  in  1  WE, active low.
- dfi_cke_i  in  1  clock enable.
- dfi_odt_i  in  1  ignored.
- dfi_reset_n_i  in  1  DRAM reset, active low.
- dfi_wrdata_i  in  32  write data beat.
- dfi_wrdata_en_i  in  1  write data beat valid.
- dfi_wrdata_mask_i  in  4  byte mask; 1 = byte not written.
- dfi_rddata_en_i  in  1  read data beat request.
- dfi_rddata_o  out  32  read data beat.
- dfi_rddata_valid_o  out  1  read data beat valid.
- dfi_rddata_dnv_o  out  2  data-not-valid; tied 2'b00.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_i low at posedge):
  - all 8 banks closed; read and write queues empty; beat counters 0; latency pipe cleared.
  - dfi_rddata_o = 0, dfi_rddata_valid_o = 0, err_o = 0.
  - RAM contents are not reset.
  - Reset mid-burst abandons the burst; no further valid beats are produced.
- Command decode: a command is sampled only when dfi_cs_n_i = 0, dfi_cke_i = 1 and dfi_reset_n_i = 1. Otherwise it is treated as NOP. {ras_n, cas_n, we_n}:
  - 011 ACT
  - 101 RD
  - 100 WR
  - 010 PRE
  - 001 REF
  - 000 MRS
  - 110 ZQ
  - 111 NOP
- Bank tracking: per bank, an open flag plus a 15-bit row register.
  - ACT: opens the bank and latches dfi_address_i. ACT to an already-open bank sets err_o; the row is still overwritten.
  - PRE with A10 = 1 closes all banks; with A10 = 0 closes dfi_bank_i.
  - REF with any bank open sets err_o.
  - MRS and ZQ have no effect.
- Burst base index: {row, bank, col[9:3], 2'b00}, truncated to its low MEM_ADDR_W bits. A burst is 4 DFI beats (BL8 x16 = 128 bits).
- RD/WR to a closed bank sets err_o and the command is dropped.
- RD/WR with the target queue full sets err_o and the command is dropped.
- RD/WR with A10 = 1 (auto-precharge) closes the bank after enqueueing.
- Write path, per cycle with dfi_wrdata_en_i = 1:
  - queue non-empty: write bytes with mask bit 0 at head base + wr_beat. wr_beat increments modulo 4; at wr_beat = 3 the head is popped.
  - queue empty: beat dropped, err_o set.
- Read path, per cycle with dfi_rddata_en_i = 1:
  - queue non-empty: address head base + rd_beat is read. rd_beat increments modulo 4; at rd_beat = 3 the head is popped.
  - queue empty: err_o set; a beat is still returned with data 0.
- Read latency: dfi_rddata_valid_o asserts exactly DDR_READ_LATENCY cycles after each sampled dfi_rddata_en_i beat, with dfi_rddata_o valid in the same cycle. It is 0 otherwise, and dfi_rddata_o holds its last value.
- Read-after-write: a read beat observes a write beat to the same word committed in any earlier cycle. Same-cycle write/read to the same word returns old data.
- Same-cycle events: a queue push and pop in the same cycle is legal, and occupancy is unchanged. A command push and a beat on the other queue are independent.
- err_o clears only on reset.

Test Plan:
- Reset, then ACT bank 2 row 0x0005, then WR bank 2 col 0x008, then 4 wrdata_en beats 0x11111111..0x44444444 with mask 0 -> err_o stays 0. Then RD bank 2 col 0x008 and 4 rddata_en beats -> valid beats exactly 4 cycles after each enable, data 0x11111111, 0x22222222, 0x33333333, 0x44444444.
- Partial write: overwrite beat 0 of the above burst with 0xAABBCCDD, mask 4'b0101 -> read back beat 0 = 0xAA11CC11.
- Error checks: RD to bank 3 never activated -> err_o = 1 next cycle, no rddata_valid. ACT bank 1 twice -> err_o = 1. rddata_en with empty read queue -> err_o = 1 and a zero beat after 4 cycles.
- Queue full: 5 back-to-back RD commands to an open bank with no rddata_en -> first 4 accepted, 5th sets err_o. Then 16 enable beats -> exactly 16 valid beats, none for the 5th.
- PRE A10 = 1 with banks 0 and 7 open, then RD bank 7 -> err_o = 1. Commands with dfi_cke_i = 0 or dfi_reset_n_i = 0 -> ignored, banks unchanged.
- Assert rst_i = 0 during the 2nd beat of a read burst -> dfi_rddata_valid_o = 0 from the next cycle on, err_o = 0, all banks closed.
